// File: rtl/array_add_pkg.sv
// array_add_pkg: shared sizes, types and reset-init functions for the array-accumulate engine.
package array_add_pkg;
  localparam int IDX_W = 8;
  localparam int DEPTH = 1 << IDX_W;
  localparam int WIDTH = 32;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [WIDTH-1:0] word_t;
  localparam logic [1:0] INIT_ZERO = 2'd0;
  localparam logic [1:0] INIT_A    = 2'd1;
  localparam logic [1:0] INIT_B    = 2'd2;
  function automatic word_t a_init(input int i);
    return word_t'(i);
  endfunction
  function automatic word_t b_init(input int i);
    return word_t'(2 * i);
  endfunction
  function automatic word_t init_val(input logic [1:0] kind, input int i);
    return kind == INIT_A ? a_init(i) : kind == INIT_B ? b_init(i) : '0;
  endfunction
endpackage

// File: rtl/array_add_regfile.sv
// array_add_regfile: DEPTH x WIDTH register array, async reset to an init pattern, one write and one read port.
module array_add_regfile
  import array_add_pkg::*;
#(
  parameter logic [1:0] INIT = INIT_ZERO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [IDX_W-1:0] ra_i,
  output logic [WIDTH-1:0] rd_o
);
  word_t mem_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= init_val(INIT, i);
    else if (we_i) mem_q[wa_i] <= wd_i;
  assign rd_o = mem_q[ra_i];
endmodule

// File: rtl/array_add.sv
// array_add: walks a wrapping index, writing C[i]=A[i]+B[i] and accumulating it into sum while run is high.
module array_add
  import array_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] sum,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  idx_t  index_q, index_d;
  word_t sum_q, sum_d, a_w, b_w, t;
  // A and B are constant after reset: their write ports are tied off.
  array_add_regfile #(.INIT(INIT_A)) u_a (
    .clk(clk), .rst(rst), .we_i(1'b0), .wa_i('0), .wd_i('0), .ra_i(index_q), .rd_o(a_w)
  );
  array_add_regfile #(.INIT(INIT_B)) u_b (
    .clk(clk), .rst(rst), .we_i(1'b0), .wa_i('0), .wd_i('0), .ra_i(index_q), .rd_o(b_w)
  );
  array_add_regfile #(.INIT(INIT_ZERO)) u_c (
    .clk(clk), .rst(rst), .we_i(run), .wa_i(index_q), .wd_i(t), .ra_i(rd_addr), .rd_o(rd_data)
  );
  always_comb begin
    t       = a_w + b_w;
    index_d = run ? index_q + idx_t'(1) : index_q;
    sum_d   = run ? sum_q + t : sum_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      index_q <= '0;
      sum_q   <= '0;
    end else begin
      index_q <= index_d;
      sum_q   <= sum_d;
    end
  assign index = index_q;
  assign sum   = sum_q;
endmodule

// File: tb/tb_array_add.sv
// tb_array_add: scoreboard bench; an arithmetic model of A+B=3i predicts index, sum and C readback.
module tb_array_add;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [7:0]  index;
  logic [31:0] sum;
  logic [31:0] rd_data;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0]  idx;
    logic [31:0] sum;
    logic [31:0] rd;
  } exp_t;
  exp_t q[$];
  logic [7:0]  m_idx;
  logic [31:0] m_sum;
  logic [31:0] m_c [256];
  array_add dut (
    .clk(clk), .rst(rst), .run(run), .index(index), .sum(sum), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, expv, $time);
    end
  endtask
  task automatic m_reset();
    m_idx = '0;
    m_sum = '0;
    for (int i = 0; i < 256; i++) m_c[i] = '0;
  endtask
  // Drive one cycle's inputs shortly after the edge and queue what the outputs must show at the next negedge.
  task automatic cyc(input logic r, input logic [7:0] a, input logic rs);
    @(posedge clk);
    #2;
    rst = rs;
    run = r;
    rd_addr = a;
    if (rs) m_reset();
    q.push_back('{m_idx, m_sum, m_c[a]});
    if (!rs && r) begin
      m_c[m_idx] = 32'(m_idx) * 3;
      m_sum = m_sum + 32'(m_idx) * 3;
      m_idx = m_idx + 8'd1;
    end
  endtask
  task automatic hold_chk(input string name, input logic [7:0] ei, input logic [31:0] es);
    cyc(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #1;
    chk({name, "_index"}, 32'(index), 32'(ei));
    chk({name, "_sum"}, sum, es);
  endtask
  task automatic rdc(input logic [7:0] a, input logic [31:0] expv);
    cyc(1'b0, a, 1'b0);
    #1;
    chk("rd_const", rd_data, expv);
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_index", 32'(index), 32'(e.idx));
      chk("sb_sum", sum, e.sum);
      chk("sb_rd_data", rd_data, e.rd);
    end
  initial begin
    m_reset();
    #1 rst = 1'b1;
    repeat (2) cyc(1'b0, 8'd7, 1'b1);
    repeat (5) cyc(1'b0, 8'd7, 1'b0);
    repeat (4) cyc(1'b1, 8'd0, 1'b0);
    hold_chk("four", 8'd4, 32'd18);
    rdc(8'd3, 32'd9);
    rdc(8'd4, 32'd0);
    hold_chk("four_held", 8'd4, 32'd18);
    cyc(1'b0, 8'd0, 1'b1);
    repeat (256) cyc(1'b1, 8'd0, 1'b0);
    hold_chk("pass1", 8'd0, 32'd97920);
    rdc(8'd10, 32'd30);
    rdc(8'd255, 32'd765);
    cyc(1'b0, 8'd0, 1'b1);
    repeat (512) cyc(1'b1, 8'd0, 1'b0);
    hold_chk("pass2", 8'd0, 32'd195840);
    rdc(8'd10, 32'd30);
    rdc(8'd255, 32'd765);
    cyc(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(i % 2 == 0, 8'd0, 1'b0);
    hold_chk("toggle", 8'd10, 32'd135);
    cyc(1'b0, 8'd0, 1'b1);
    repeat (100) cyc(1'b1, 8'd5, 1'b0);
    hold_chk("hundred", 8'd100, 32'd14850);
    cyc(1'b0, 8'd5, 1'b1);
    #1;
    chk("async_index", 32'(index), 32'd0);
    chk("async_sum", sum, 32'd0);
    chk("async_rd_data", rd_data, 32'd0);
    repeat (4) cyc(1'b1, 8'd0, 1'b0);
    hold_chk("after_reset", 8'd4, 32'd18);
    repeat (400) cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 63) == 0);
    repeat (2) cyc(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/array_add.md
Name: array_add

Overview:
- Self-contained array-accumulate engine, used as the golden design in the fault-injection comparison sample (plain and injected copies run in lockstep).
- Holds two operand arrays A and B and a result array C, each DEPTH×WIDTH.
- While `run` is high it walks a wrapping index. Each step it writes C[i]=A[i]+B[i] and accumulates that value into a running `sum`.
- `index` and `sum` are exported every cycle for cycle-by-cycle comparison.

Parameters:
- DEPTH, 256, number of entries per array; must equal 2**IDX_W.
- IDX_W, 8, width of index / address.
- WIDTH, 32, data width of arrays and sum.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- run  input  1  advance enable; sampled on rising clk.
- index  output  IDX_W  current array position (registered).
- sum  output  WIDTH  running accumulation (registered).
- rd_addr  input  IDX_W  readback address into C.
- rd_data  output  WIDTH  combinational read of C[rd_addr].

Behaviour:
- Reset values (asynchronous assertion, synchronous-safe release):
  - index=0, sum=0.
  - A[i]=i, zero-extended to WIDTH.
  - B[i]=2*i mod 2^WIDTH.
  - C[i]=0 for all i.
  - A and B are reset-initialised registers; no external write path.
- Step (rising clk with rst=0 and run=1), with t=A[index]+B[index] mod 2^WIDTH:
  - C[index] <= t.
  - sum <= sum + t mod 2^WIDTH; overflow silently wraps, no carry-out.
  - index <= index+1 mod DEPTH; DEPTH-1 wraps to 0.
- Hold (rising clk with run=0): index, sum, C unchanged.
- Latency: one cycle. Outputs reflect the step on the clock edge after run is sampled high.
- Closed form: after N consecutive steps from reset:
  - index = N mod 256.
  - sum = 3·N(N−1)/2 for N ≤ 256.
  - Each full pass of 256 steps adds 97920 (0x00017E80).
- Second and later passes rewrite C with identical values, so C is stable after the first pass.
- rd_data is combinational from C. If rd_addr equals the index being written this cycle, rd_data shows the old value until the edge.
- Reset mid-operation: all state returns immediately to reset values regardless of run or clk; the step in progress is discarded.
- run toggling every cycle: only high cycles step; no state is lost.
- No X on any output after reset; all array entries have defined reset values.

Decomposition:
- Shared package `array_add_pkg` holds:
  - constants DEPTH, IDX_W, WIDTH;
  - typedefs idx_t (logic [IDX_W-1:0]) and word_t (logic [WIDTH-1:0]);
  - init functions a_init(i)=i and b_init(i)=2*i.
- One natural sub-module, `array_add_regfile`: a DEPTH×WIDTH register array with async reset to an init function, one write port and one or two combinational read ports.
  - Instantiate three times: A and B with write disabled, C with write enabled.
- Index counter and accumulator stay in the top.

Test Plan:
- Assert rst for 2 cycles, release with run=0, hold 5 cycles -> index=0, sum=0, rd_data(rd_addr=7)=0 throughout.
- run=1 for exactly 4 cycles, then run=0 -> index=4, sum=18 (0+3+6+9), stays held. rd_addr=3 -> 9; rd_addr=4 -> 0.
- run=1 for 256 cycles from reset -> index=0, sum=97920 (0x00017E80). rd_addr=10 -> 30; rd_addr=255 -> 765.
- run=1 for 512 cycles from reset -> index=0, sum=195840 (0x0002FD00); C unchanged from the first pass.
- Alternate run 1/0 each cycle for 20 cycles -> 10 steps: index=10, sum=135.
- After 100 steps (sum=14850), pulse rst asynchronously between clock edges -> index=0, sum=0 and rd_data(rd_addr=5)=0 immediately. A subsequent 4 steps give sum=18.
